// File: rtl/imm_extend_pipe_if.sv
// Handshake bus for the immediate-extension pipe.
// Signal names are taken from the block's point of view: *_i flows into the
// block and *_o flows out of it.
`timescale 1ns/1ps
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  data_i;
    logic [1:0]       mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;

    // The extension block itself.
    modport slave (
        input  valid_i, data_i, mode_i, ready_i,
        output ready_o, valid_o, data_o
    );

    // The environment: upstream producer plus downstream consumer.
    modport master (
        output valid_i, data_i, mode_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry output FIFO.
// The immediate is extended once, on the edge that accepts it, and the result
// is stored. data_o shows the oldest stored result and reads as zero while the
// FIFO is empty. xfer_cnt_o counts the results delivered downstream.
`timescale 1ns/1ps
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    imm_extend_pipe_if.slave    bus,
    output logic [15:0]         xfer_cnt_o
);

    // Branch-offset mode drops the top two bits of the sign-extended value,
    // so at least two extension bits must exist.
    if (OUT_W < IN_W + 2) begin : g_bad_params
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    localparam int EXT_W = OUT_W - IN_W;

    // FIFO state
    logic [OUT_W-1:0] mem_q [2];
    logic [OUT_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] ext_val;

    // Handshake flags depend only on the stored count, so ready_o never sees
    // ready_i combinationally.
    assign bus.ready_o = (count_q < 2'd2);
    assign bus.valid_o = (count_q != 2'd0);
    assign bus.data_o  = bus.valid_o ? mem_q[rd_ptr_q] : '0;
    assign xfer_cnt_o  = xfer_cnt_q;

    assign push = bus.valid_i && bus.ready_o;
    assign pop  = bus.valid_o && bus.ready_i;

    assign sext_val = {{EXT_W{bus.data_i[IN_W-1]}}, bus.data_i};

    // Extend the offered immediate according to its mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        ext_val = sext_val;
        case (mode_e'(bus.mode_i))
            MODE_SEXT:   ext_val = sext_val;
            MODE_ZEXT:   ext_val = {{EXT_W{1'b0}}, bus.data_i};
            MODE_UPPER:  ext_val = {bus.data_i, {EXT_W{1'b0}}};
            MODE_BRANCH: ext_val = {sext_val[OUT_W-3:0], 2'b00};
            default:     ext_val = sext_val;
        endcase
    end

    // Next-state for storage, pointers, occupancy and the delivery counter.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        xfer_cnt_d = xfer_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = ext_val;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            xfer_cnt_d = xfer_cnt_q + 16'd1;  // wraps 0xFFFF -> 0x0000
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Register all state; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: the entries are reset as well as the pointers, so a reset
            // leaves no trace of previously stored results in the array.
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            xfer_cnt_q <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

endmodule
